// File: rtl/pll_reset_pkg.sv
// ============================================================================
//  Module  : pll_reset_pkg
//  Brief   : Shared state encoding, default timing constants and helpers for
//            the PLL reset sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_MEM_REL   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam int c_DEF_PLL_RST_CYCLES = 16;
    localparam int c_DEF_LOCK_TIMEOUT   = 65536;
    localparam int c_DEF_STABLE_CYCLES  = 1024;
    localparam int c_DEF_MEM_DELAY      = 256;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Event counters stick at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module  : sync_2ff
//  Brief   : Two-flop synchroniser with synchronous reset to RST_VAL.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
//  Module  : pll_reset_sequencer
//  Brief   : Sequences PLL, memory and system resets from the PLL lock flag,
//            with lock timeout retry, lock-loss recovery and software restart.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES = c_DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = c_DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = c_DEF_STABLE_CYCLES,
    parameter int MEM_DELAY      = c_DEF_MEM_DELAY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       mem_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] retry_cnt
);

    localparam int c_CNT_W = $clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                         STABLE_CYCLES, MEM_DELAY)) + 1;

    localparam logic [c_CNT_W-1:0] c_LD_PLL  = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LD_LOCK = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_LD_MEM  = c_CNT_W'(MEM_DELAY - 1);
    // The WAIT_LOCK cycle that first sees lock already counts as one stable cycle.
    localparam logic [c_CNT_W-1:0] c_LD_STB  =
        c_CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

    logic               w_locked;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pll_rst;
    logic               r_mem_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic [7:0]         r_lock_loss;
    logic [7:0]         r_retry;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (w_locked)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= c_LD_PLL;
            r_pll_rst   <= 1'b1;
            r_mem_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_loss <= 8'd0;
            r_retry     <= 8'd0;
        end else if (sw_reset_req) begin
            r_state   <= ST_PLL_RST;
            r_cnt     <= c_LD_PLL;
            r_pll_rst <= 1'b1;
            r_mem_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_cnt     <= c_LD_LOCK;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= c_LD_STB;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_PLL_RST;
                        r_cnt     <= c_LD_PLL;
                        r_pll_rst <= 1'b1;
                        r_retry   <= sat_inc(r_retry);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= c_LD_LOCK;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_MEM_REL;
                        r_cnt     <= c_LD_MEM;
                        r_mem_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_MEM_REL, ST_RUN: begin
                    // Lock loss re-waits for lock without pulsing the PLL reset.
                    if (!w_locked) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_cnt       <= c_LD_LOCK;
                        r_mem_rst   <= 1'b1;
                        r_sys_rst   <= 1'b1;
                        r_ready     <= 1'b0;
                        r_lock_loss <= sat_inc(r_lock_loss);
                    end else if (r_state == ST_MEM_REL) begin
                        if (r_cnt == '0) begin
                            r_state   <= ST_RUN;
                            r_sys_rst <= 1'b0;
                            r_ready   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_PLL_RST;
                    r_cnt     <= c_LD_PLL;
                    r_pll_rst <= 1'b1;
                    r_mem_rst <= 1'b1;
                    r_sys_rst <= 1'b1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst       = r_pll_rst;
    assign mem_rst       = r_mem_rst;
    assign sys_rst       = r_sys_rst;
    assign ready         = r_ready;
    assign state_o       = r_state;
    assign lock_loss_cnt = r_lock_loss;
    assign retry_cnt     = r_retry;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
//  Module  : tb_pll_reset_sequencer
//  Brief   : Self-checking bench; expected event times follow from the
//            sequencing rules as timestamp arithmetic on a cycle counter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

    localparam int c_PRC = 16;
    localparam int c_TO  = 100;
    localparam int c_ST  = 20;
    localparam int c_MD  = 10;
    localparam int c_SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       mem_rst;
    logic       sys_rst;
    logic       ready;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt;
    logic [7:0] retry_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (c_PRC),
        .LOCK_TIMEOUT   (c_TO),
        .STABLE_CYCLES  (c_ST),
        .MEM_DELAY      (c_MD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .pll_rst       (pll_rst),
        .mem_rst       (mem_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return pll_rst;
            1:       return mem_rst;
            2:       return sys_rst;
            default: return ready;
        endcase
    endfunction

    task automatic wait_sig(input int k, input logic v, input int budget,
                            input string tag, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sig(k) === v) begin
                t = cyc;
                break;
            end
        end
        check({tag, "_reached"}, 32'(sig(k)), 32'(v));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},   32'(pll_rst), 1);
        check({tag, "_mem_rst"},   32'(mem_rst), 1);
        check({tag, "_sys_rst"},   32'(sys_rst), 1);
        check({tag, "_ready"},     32'(ready), 0);
        check({tag, "_state"},     32'(state_o), 0);
        check({tag, "_lock_loss"}, 32'(lock_loss_cnt), 0);
        check({tag, "_retry"},     32'(retry_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, t1, t2, base, d, k, p;
        rst          = 1'b1;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        step();
        step();
        check_reset_values("por");

        // Power-up: pll_rst pulse, then lock 5 cycles after it falls.
        rst  = 1'b0;
        base = cyc;
        wait_sig(0, 1'b0, 40, "pll_fall0", t);
        check("pll_rst_width0", t - base, c_PRC);
        check("mem_rst_held_wait", 32'(mem_rst), 1);
        repeat (5) step();
        pll_locked = 1'b1;
        base = cyc + c_SYNC;
        wait_sig(1, 1'b0, 100, "mem_fall_nom", t);
        check("mem_rel_delay", t - base, c_ST);
        check("sys_held_memrel", 32'(sys_rst), 1);
        wait_sig(2, 1'b0, 60, "sys_fall_nom", t1);
        check("sys_rel_delay", t1 - t, c_MD);
        check("ready_run", 32'(ready), 1);
        check("state_run", 32'(state_o), 4);

        // Lock loss in RUN, then relock after a random gap.
        k = $urandom_range(3, 20);
        repeat (k) step();
        pll_locked = 1'b0;
        base = cyc;
        wait_sig(1, 1'b1, 10, "mem_assert_loss", t);
        check("loss_latency", t - base, c_SYNC + 1);
        check("loss_sys_rst", 32'(sys_rst), 1);
        check("loss_pll_rst", 32'(pll_rst), 0);
        check("loss_cnt1", 32'(lock_loss_cnt), 1);
        check("loss_state", 32'(state_o), 1);
        d = $urandom_range(1, 40);
        repeat (d) step();
        pll_locked = 1'b1;
        base = cyc;
        wait_sig(3, 1'b1, 100, "ready_relock", t);
        check("relock_ready_delay", t - base, c_SYNC + c_ST + c_MD);

        // Software restart in the same cycle the lock loss is seen.
        k = $urandom_range(2, 10);
        repeat (k) step();
        pll_locked = 1'b0;
        step();
        step();
        sw_reset_req = 1'b1;
        base = cyc + 1;
        step();
        sw_reset_req = 1'b0;
        check("sw_pll_rst", 32'(pll_rst), 1);
        check("sw_state", 32'(state_o), 0);
        check("sw_loss_unchanged", 32'(lock_loss_cnt), 1);
        wait_sig(0, 1'b0, 40, "sw_pll_fall", t);
        check("sw_pll_rst_width", t - base, c_PRC);

        // One-cycle lock glitch while in STABLE restarts the stable count.
        d = $urandom_range(1, 30);
        repeat (d) step();
        pll_locked = 1'b1;
        k = $urandom_range(0, 15);
        repeat (c_SYNC + k) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        step();
        p = cyc;
        check("glitch_state", 32'(state_o), 1);
        check("glitch_mem_rst", 32'(mem_rst), 1);
        check("glitch_sys_rst", 32'(sys_rst), 1);
        check("glitch_pll_rst", 32'(pll_rst), 0);
        check("glitch_loss_cnt", 32'(lock_loss_cnt), 1);
        wait_sig(1, 1'b0, 100, "glitch_mem_fall", t);
        check("glitch_full_recount", t - p, c_ST);
        wait_sig(2, 1'b0, 60, "glitch_sys_fall", t1);
        check("glitch_sys_delay", t1 - t, c_MD);

        // Never locking: periodic PLL reset retries.
        pll_locked   = 1'b0;
        sw_reset_req = 1'b1;
        base = cyc + 1;
        step();
        sw_reset_req = 1'b0;
        wait_sig(0, 1'b0, 40, "to_pll_fall", t0);
        check("to_first_width", t0 - base, c_PRC);
        for (int i = 0; i < 3; i++) begin
            wait_sig(0, 1'b1, c_TO + 20, "to_rise", t1);
            check("timeout_len", t1 - t0, c_TO);
            wait_sig(0, 1'b0, c_PRC + 10, "to_fall", t2);
            check("retry_pulse_width", t2 - t1, c_PRC);
            t0 = t2;
        end
        check("retry_cnt3", 32'(retry_cnt), 3);
        for (int i = 0; i < 257; i++) begin
            wait_sig(0, 1'b1, c_TO + 20, "sat_rise", t1);
            wait_sig(0, 1'b0, c_PRC + 10, "sat_fall", t2);
        end
        check("retry_saturated", 32'(retry_cnt), 255);
        check("loss_cnt_kept", 32'(lock_loss_cnt), 1);

        // Block reset asserted in MEM_REL.
        pll_locked = 1'b1;
        wait_sig(1, 1'b0, 150, "mr_mem_fall", t);
        k = $urandom_range(1, 8);
        repeat (k) step();
        check("mr_state_memrel", 32'(state_o), 3);
        rst        = 1'b1;
        pll_locked = 1'b0;
        step();
        check_reset_values("midrst");
        step();
        rst  = 1'b0;
        base = cyc;
        wait_sig(0, 1'b0, 40, "mr_pll_fall", t);
        check("mr_pll_rst_width", t - base, c_PRC);
        d = $urandom_range(1, 50);
        repeat (d) step();
        pll_locked = 1'b1;
        base = cyc;
        wait_sig(3, 1'b1, 100, "mr_ready", t);
        check("mr_ready_delay", t - base, c_SYNC + c_ST + c_MD);
        check("mr_retry_zero", 32'(retry_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
